// File: rtl/home_pkg.sv
`default_nettype none
// ============================================================================
// Module      : home_pkg
// Description : Shared alarm definitions for the home controller slice:
//               alarm bit positions, priority codes, annunciator states and
//               the priority encoder used to derive the active alarm code.
// Revision    : 1.0 - initial release
// ============================================================================
package home_pkg;

  // Bit positions inside the 3-bit alarms / latched vectors
  localparam int c_bit_fire      = 2;
  localparam int c_bit_intrusion = 1;
  localparam int c_bit_rain      = 0;

  // Alarm codes, ordered so that a larger value means a more serious alarm
  typedef enum logic [1:0] {
    NONE      = 2'd0,
    RAIN      = 2'd1,
    INTRUSION = 2'd2,
    FIRE      = 2'd3
  } alarm_code_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALERT    = 2'd1,
    DIAL     = 2'd2,
    WAIT_CLR = 2'd3
  } annun_state_t;

  // Priority encoder: fire > intrusion > rain
  function automatic alarm_code_t code_of(input logic [2:0] a);
    if (a[c_bit_fire])           return FIRE;
    else if (a[c_bit_intrusion]) return INTRUSION;
    else if (a[c_bit_rain])      return RAIN;
    else                         return NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/siren_cadence.sv
`default_nettype none
// ============================================================================
// Module      : siren_cadence
// Description : Siren on/off cadence generator. A phase counter runs over
//               SIREN_ON+SIREN_OFF steps; the registered output is high for
//               phases 0..SIREN_ON-1. restart forces phase 0, enable lets the
//               counter advance and allows the output to go high.
//               SIREN_ON+SIREN_OFF must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module siren_cadence #(
  parameter int SIREN_ON  = 4,
  parameter int SIREN_OFF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic out
);

  localparam int PERIOD = SIREN_ON + SIREN_OFF;
  localparam int PW     = $clog2(PERIOD);

  localparam logic [PW-1:0] c_phase_last = PW'(PERIOD - 1);
  localparam logic [PW-1:0] c_on_last    = PW'(SIREN_ON - 1);

  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase_next;
  logic          r_out;

  // Next phase with wrap at the end of the period
  always_comb begin
    w_phase_next = r_phase + 1'b1;
    if (r_phase == c_phase_last) begin
      w_phase_next = '0;
    end
  end

  // Phase counter and registered siren level for the phase being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
      r_out   <= 1'b0;
    end else if (restart) begin
      r_phase <= '0;
      r_out   <= enable;
    end else if (enable) begin
      r_phase <= w_phase_next;
      r_out   <= (w_phase_next <= c_on_last);
    end else begin
      r_out   <= 1'b0;
    end
  end

  assign out = r_out;

endmodule
`default_nettype wire

// File: rtl/alarm_annunciator.sv
`default_nettype none
// ============================================================================
// Module      : alarm_annunciator
// Description : Latches and prioritises home alarms, drives siren/strobe,
//               accepts a user acknowledge and escalates unacknowledged
//               serious alarms to a dial-out unit with bounded retries.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_annunciator
  import home_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int SIREN_ON    = 4,
  parameter int SIREN_OFF   = 4,
  parameter int RETRY_MAX   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] alarms,
  input  logic [7:0] occupants_in,
  input  logic       ack,
  input  logic       dial_ack,
  output logic [2:0] latched,
  output logic [1:0] active_code,
  output logic       siren,
  output logic       strobe,
  output logic       dial_req,
  output logic [1:0] dial_code,
  output logic       dial_fail
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);

  // Each ALERT period and each dial attempt lasts ACK_TIMEOUT cycles,
  // the timer counting 0 .. ACK_TIMEOUT-1 within it.
  localparam logic [TW-1:0] c_timer_last = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] c_timer_sat  = TW'(ACK_TIMEOUT);
  localparam logic [RW-1:0] c_retry_max  = RW'(RETRY_MAX);

  annun_state_t r_state;
  logic [2:0]   r_latched;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_retry;
  logic         r_strobe;
  logic         r_dial_req;
  logic [1:0]   r_dial_code;
  logic         r_dial_fail;

  logic [2:0]   w_clr_mask;
  logic [2:0]   w_latched_next;
  alarm_code_t  w_code;
  alarm_code_t  w_code_next;
  logic         w_timer_expired;
  logic [TW-1:0] w_timer_inc;
  logic [RW-1:0] w_retry_inc;
  logic         w_escalate;
  logic         w_to_idle;
  logic         w_cad_restart;
  logic         w_cad_enable;
  logic         w_siren;

  // Sticky latch: ack may only clear bits whose raw input is low
  assign w_clr_mask     = ack ? ~alarms : 3'b000;
  assign w_latched_next = (r_latched & ~w_clr_mask) | alarms;

  assign w_code      = code_of(r_latched);
  assign w_code_next = code_of(w_latched_next);

  assign w_timer_expired = (r_timer == c_timer_last);
  assign w_timer_inc     = (r_timer == c_timer_sat) ? r_timer : r_timer + 1'b1;
  assign w_retry_inc     = r_retry + 1'b1;

  // Fire always escalates; intrusion only when nobody is home
  assign w_escalate = (w_code == FIRE) ||
                      ((w_code == INTRUSION) && (occupants_in == 8'd0));

  // True when the FSM will be (or stay) in IDLE after this edge
  assign w_to_idle = ((r_state == IDLE)     && (r_latched == 3'b000)) ||
                     ((r_state == ALERT)    && (w_latched_next == 3'b000)) ||
                     ((r_state == WAIT_CLR) && (r_latched == 3'b000));

  // Cadence restarts on every alarm entry; siren sounds for intrusion or fire
  assign w_cad_restart = (r_state == IDLE) && (r_latched != 3'b000);
  assign w_cad_enable  = !w_to_idle && (w_code_next >= INTRUSION);

  siren_cadence #(
    .SIREN_ON (SIREN_ON),
    .SIREN_OFF(SIREN_OFF)
  ) u_cadence (
    .clk    (clk),
    .reset  (reset),
    .restart(w_cad_restart),
    .enable (w_cad_enable),
    .out    (w_siren)
  );

  // Alarm latch, escalation FSM, timers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_latched   <= 3'b000;
      r_timer     <= '0;
      r_retry     <= '0;
      r_strobe    <= 1'b0;
      r_dial_req  <= 1'b0;
      r_dial_code <= 2'd0;
      r_dial_fail <= 1'b0;
    end else begin
      r_latched <= w_latched_next;
      r_strobe  <= !w_to_idle;
      case (r_state)
        IDLE: begin
          r_timer     <= '0;
          r_retry     <= '0;
          r_dial_req  <= 1'b0;
          r_dial_code <= 2'd0;
          if (r_latched != 3'b000) begin
            r_state <= ALERT;
          end
        end

        ALERT: begin
          // ack outranks a coincident timeout
          if (w_latched_next == 3'b000) begin
            r_state <= IDLE;
            r_timer <= '0;
          end else if (ack) begin
            r_timer <= '0;
          end else if (w_timer_expired) begin
            r_timer <= '0;
            if (w_escalate) begin
              r_state     <= DIAL;
              r_dial_req  <= 1'b1;
              r_dial_code <= w_code;
              r_retry     <= '0;
            end
          end else begin
            r_timer <= w_timer_inc;
          end
        end

        DIAL: begin
          if (r_dial_req) begin
            // dial_ack coincident with a timeout still counts as success
            if (dial_ack) begin
              r_dial_req <= 1'b0;
              r_timer    <= '0;
              r_state    <= WAIT_CLR;
            end else if (w_timer_expired) begin
              r_dial_req <= 1'b0;
              r_timer    <= '0;
              r_retry    <= w_retry_inc;
              if (w_retry_inc == c_retry_max) begin
                r_dial_fail <= 1'b1;
                r_state     <= WAIT_CLR;
              end
            end else begin
              r_timer <= w_timer_inc;
            end
          end else begin
            // single-cycle gap between attempts, then request again
            r_dial_req <= 1'b1;
            r_timer    <= '0;
          end
        end

        WAIT_CLR: begin
          if (w_code > r_dial_code) begin
            r_state     <= DIAL;
            r_dial_req  <= 1'b1;
            r_dial_code <= w_code;
            r_retry     <= '0;
            r_timer     <= '0;
          end else if (r_latched == 3'b000) begin
            r_state     <= IDLE;
            r_dial_fail <= 1'b0;
            r_dial_code <= 2'd0;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign latched     = r_latched;
  assign active_code = w_code;
  assign siren       = w_siren;
  assign strobe      = r_strobe;
  assign dial_req    = r_dial_req;
  assign dial_code   = r_dial_code;
  assign dial_fail   = r_dial_fail;

endmodule
`default_nettype wire

// File: tb/tb_alarm_annunciator.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_annunciator
// Description : Self-checking bench for alarm_annunciator. Expected output
//               vectors are queued as stimulus is applied and compared one
//               cycle later against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_annunciator;

  localparam int ACK_TIMEOUT = 16;
  localparam int SIREN_ON    = 4;
  localparam int SIREN_OFF   = 4;
  localparam int RETRY_MAX   = 3;

  // Observed vector: {latched[3], code[2], siren, strobe, req, dcode[2], fail}
  localparam logic [10:0] M_ALL   = 11'h7FF;
  localparam logic [10:0] M_LAT   = 11'h700;
  localparam logic [10:0] M_SIREN = 11'h020;
  localparam logic [10:0] M_REQ   = 11'h008;
  localparam logic [10:0] M_DCODE = 11'h006;
  localparam logic [10:0] M_FAIL  = 11'h001;

  typedef struct {
    logic [10:0] val;
    logic [10:0] mask;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] alarms;
  logic [7:0] occupants_in;
  logic       ack;
  logic       dial_ack;
  logic [2:0] latched;
  logic [1:0] active_code;
  logic       siren;
  logic       strobe;
  logic       dial_req;
  logic [1:0] dial_code;
  logic       dial_fail;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  alarm_annunciator #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .SIREN_ON   (SIREN_ON),
    .SIREN_OFF  (SIREN_OFF),
    .RETRY_MAX  (RETRY_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alarms      (alarms),
    .occupants_in(occupants_in),
    .ack         (ack),
    .dial_ack    (dial_ack),
    .latched     (latched),
    .active_code (active_code),
    .siren       (siren),
    .strobe      (strobe),
    .dial_req    (dial_req),
    .dial_code   (dial_code),
    .dial_fail   (dial_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs_now();
    return {latched, active_code, siren, strobe, dial_req, dial_code, dial_fail};
  endfunction

  function automatic logic [10:0] mk(input logic [2:0] lat, input logic [1:0] code,
                                     input logic sir, input logic stb, input logic req,
                                     input logic [1:0] dcode, input logic fail);
    return {lat, code, sir, stb, req, dcode, fail};
  endfunction

  // Expected siren after edge k when the alarm entered ALERT on edge 1
  function automatic logic cad(input int k);
    return (k >= 1) && (((k - 1) % (SIREN_ON + SIREN_OFF)) < SIREN_ON);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] a, input logic [7:0] occ,
                       input logic ak, input logic dak);
    alarms       = a;
    occupants_in = occ;
    ack          = ak;
    dial_ack     = dak;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [10:0] o;
    reset = 1'b1;
    drive(3'b000, 8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{val: 11'h000, mask: M_ALL, cyc: k});
      tick();
      e = sb.pop_front();
      o = obs_now();
      n_cmp++;
      if ((o & e.mask) !== (e.val & e.mask)) begin
        n_mis++;
        $display("FAIL reset k=%0d got=%b want=%b mask=%b", e.cyc, o, e.val, e.mask);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_rain();
    exp_t e;
    logic [10:0] o;
    for (int k = 0; k <= 6; k++) begin
      drive((k == 0) ? 3'b001 : 3'b000, 8'd1, (k == 5), 1'b0);
      if (k == 0)     sb.push_back('{val: mk(3'b001, 2'd1, 0, 0, 0, 2'd0, 0), mask: M_ALL, cyc: k});
      else if (k < 5) sb.push_back('{val: mk(3'b001, 2'd1, 0, 1, 0, 2'd0, 0), mask: M_ALL, cyc: k});
      else            sb.push_back('{val: 11'h000, mask: M_ALL, cyc: k});
      tick();
      e = sb.pop_front();
      o = obs_now();
      n_cmp++;
      if ((o & e.mask) !== (e.val & e.mask)) begin
        n_mis++;
        $display("FAIL rain k=%0d got=%b want=%b mask=%b", e.cyc, o, e.val, e.mask);
      end
    end
  endtask

  task automatic test_fire_dial();
    exp_t e;
    logic [10:0] o;
    for (int k = 0; k <= 23; k++) begin
      drive((k <= 21) ? 3'b100 : 3'b000, 8'd1, (k == 22), (k == 20));
      if (k <= 21)
        sb.push_back('{val: mk(3'b100, 2'd3, cad(k), (k >= 1), (k >= 17 && k <= 19),
                               (k >= 17) ? 2'd3 : 2'd0, 0), mask: M_ALL, cyc: k});
      else if (k == 22)
        sb.push_back('{val: 11'h000, mask: M_LAT, cyc: k});
      else
        sb.push_back('{val: 11'h000, mask: M_ALL, cyc: k});
      tick();
      e = sb.pop_front();
      o = obs_now();
      n_cmp++;
      if ((o & e.mask) !== (e.val & e.mask)) begin
        n_mis++;
        $display("FAIL fire_dial k=%0d got=%b want=%b mask=%b", e.cyc, o, e.val, e.mask);
      end
    end
  endtask

  task automatic test_intrusion();
    exp_t e;
    logic [10:0] o;
    for (int k = 0; k <= 84; k++) begin
      drive((k <= 82) ? 3'b010 : 3'b000, (k <= 66) ? 8'd2 : 8'd0, (k == 83), (k == 82));
      if (k <= 81)
        sb.push_back('{val: mk(3'b010, 2'd2, cad(k), (k >= 1), (k == 81),
                               (k == 81) ? 2'd2 : 2'd0, 0), mask: M_ALL, cyc: k});
      else if (k == 82)
        sb.push_back('{val: 11'h000, mask: M_REQ, cyc: k});
      else if (k == 83)
        sb.push_back('{val: 11'h000, mask: M_LAT, cyc: k});
      else
        sb.push_back('{val: 11'h000, mask: M_ALL, cyc: k});
      tick();
      e = sb.pop_front();
      o = obs_now();
      n_cmp++;
      if ((o & e.mask) !== (e.val & e.mask)) begin
        n_mis++;
        $display("FAIL intrusion k=%0d got=%b want=%b mask=%b", e.cyc, o, e.val, e.mask);
      end
    end
  endtask

  task automatic test_retries();
    exp_t e;
    logic [10:0] o;
    logic        req;
    for (int k = 0; k <= 72; k++) begin
      drive((k <= 70) ? 3'b100 : 3'b000, 8'd1, (k == 71), 1'b0);
      req = (k >= 17 && k <= 32) || (k >= 34 && k <= 49) || (k >= 51 && k <= 66);
      if (k <= 70)
        sb.push_back('{val: mk(3'b100, 2'd3, cad(k), (k >= 1), req,
                               (k >= 17) ? 2'd3 : 2'd0, (k >= 67)), mask: M_ALL, cyc: k});
      else if (k == 71)
        sb.push_back('{val: mk(3'b000, 2'd0, 0, 0, 0, 2'd0, 1), mask: M_LAT | M_FAIL, cyc: k});
      else
        sb.push_back('{val: 11'h000, mask: M_ALL, cyc: k});
      tick();
      e = sb.pop_front();
      o = obs_now();
      n_cmp++;
      if ((o & e.mask) !== (e.val & e.mask)) begin
        n_mis++;
        $display("FAIL retries k=%0d got=%b want=%b mask=%b", e.cyc, o, e.val, e.mask);
      end
    end
  endtask

  task automatic test_upgrade();
    exp_t e;
    logic [10:0] o;
    logic [2:0]  a;
    for (int k = 0; k <= 25; k++) begin
      a = (k <= 20) ? 3'b010 : ((k <= 23) ? 3'b110 : 3'b000);
      drive(a, 8'd0, (k == 3 || k == 24), (k == 20 || k == 23));
      if (k <= 19)
        sb.push_back('{val: mk(3'b010, 2'd2, cad(k), (k >= 1), (k == 19),
                               (k == 19) ? 2'd2 : 2'd0, 0), mask: M_ALL, cyc: k});
      else if (k == 20)
        sb.push_back('{val: mk(3'b010, 2'd2, cad(k), 1, 0, 2'd2, 0), mask: M_ALL, cyc: k});
      else if (k == 21)
        sb.push_back('{val: mk(3'b110, 2'd3, cad(k), 1, 0, 2'd2, 0), mask: M_ALL, cyc: k});
      else if (k == 22)
        sb.push_back('{val: mk(3'b110, 2'd3, cad(k), 1, 1, 2'd3, 0), mask: M_ALL, cyc: k});
      else if (k == 23)
        sb.push_back('{val: mk(3'b000, 2'd0, 0, 0, 0, 2'd3, 0), mask: M_REQ | M_DCODE, cyc: k});
      else if (k == 24)
        sb.push_back('{val: 11'h000, mask: M_LAT, cyc: k});
      else
        sb.push_back('{val: 11'h000, mask: M_ALL, cyc: k});
      tick();
      e = sb.pop_front();
      o = obs_now();
      n_cmp++;
      if ((o & e.mask) !== (e.val & e.mask)) begin
        n_mis++;
        $display("FAIL upgrade k=%0d got=%b want=%b mask=%b", e.cyc, o, e.val, e.mask);
      end
    end
  endtask

  task automatic test_reset_mid_dial();
    exp_t e;
    logic [10:0] o;
    for (int k = 0; k <= 18; k++) begin
      drive(3'b100, 8'd1, 1'b0, 1'b0);
      if (k >= 17)
        sb.push_back('{val: mk(3'b100, 2'd3, 1, 1, 1, 2'd3, 0), mask: M_ALL, cyc: k});
      tick();
      if (k >= 17) begin
        e = sb.pop_front();
        o = obs_now();
        n_cmp++;
        if ((o & e.mask) !== (e.val & e.mask)) begin
          n_mis++;
          $display("FAIL reset_mid_dial pre k=%0d got=%b want=%b mask=%b", e.cyc, o, e.val, e.mask);
        end
      end
    end
    // Asynchronous reset between edges must clear outputs at once
    sb.push_back('{val: 11'h000, mask: M_LAT | M_SIREN | M_REQ | M_FAIL, cyc: 19});
    #2;
    reset = 1'b1;
    drive(3'b000, 8'd1, 1'b0, 1'b0);
    #1;
    e = sb.pop_front();
    o = obs_now();
    n_cmp++;
    if ((o & e.mask) !== (e.val & e.mask)) begin
      n_mis++;
      $display("FAIL reset_mid_dial async got=%b want=%b mask=%b", o, e.val, e.mask);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{val: 11'h000, mask: M_ALL, cyc: 20 + k});
      tick();
      e = sb.pop_front();
      o = obs_now();
      n_cmp++;
      if ((o & e.mask) !== (e.val & e.mask)) begin
        n_mis++;
        $display("FAIL reset_mid_dial post k=%0d got=%b want=%b mask=%b", e.cyc, o, e.val, e.mask);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rain();
    test_fire_dial();
    test_intrusion();
    test_retries();
    test_upgrade();
    test_reset_mid_dial();
    if (sb.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
`default_nettype wire
